seq_multiplier: RTL and testbench

- Parametrised sequential shift-add multiplier. It is the successor to the fixed 4-bit combinational multiplier.
- Adds configurable operand width, a per-operation signed/unsigned mode, and valid/ready handshakes on both input and output.
- Uses one adder per iteration, so the block can sit between a datapath producer and consumer without breaking timing at large WIDTH.

---
 rtl/seq_mult_pkg.sv | 22 ++
 rtl/seq_mult_datapath.sv | 97 +++++++++
 rtl/seq_multiplier.sv | 97 +++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t : controller states
//   abs_w   : two's-complement magnitude on a wide vector; callers sign-extend
//             their operand to ABS_MAX_W bits and truncate the result back to
//             their own width (supports WIDTH up to ABS_MAX_W)
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ABS_MAX_W = 64;

  // Magnitude of a sign-extended value; the most negative WIDTH-bit value
  // becomes 2^(WIDTH-1), which is exact once truncated to WIDTH bits.
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] x);
    return x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator,
// shift registers, iteration counter and final sign correction.
//   clk, rst_n     : clock, async active-low reset (clears all state)
//   load           : capture a/b/signed_mode and clear accumulator/counter
//   step           : perform one shift-add iteration
//   a, b           : multiplicand, multiplier
//   signed_mode    : 1 = two's-complement operands
//   last_c         : current step is the final iteration (combinational)
//   product        : registered result, updated on the final iteration
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               last_c,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    sum;

  assign product = product_q;

  // Next-state for the iteration registers and the result register.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    a_mag = a;
    b_mag = b;
    if (signed_mode) begin
      a_mag = WIDTH'(abs_w(ABS_MAX_W'(signed'(a))));
      b_mag = WIDTH'(abs_w(ABS_MAX_W'(signed'(b))));
    end

    // The multiplicand register is pre-shifted, so it always equals mag_a<<count.
    sum    = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    last_c = (cnt_q == CW'(WIDTH - 1));

    if (load) begin
      acc_d    = '0;
      mcand_d  = PW'(a_mag);
      mplier_d = b_mag;
      cnt_d    = '0;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_c) begin
        product_d = neg_q ? (~sum + PW'(1)) : sum;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// One accumulate per clock; a result appears WIDTH edges after acceptance.
//   clk, rst_n   : clock, async active-low reset
//   in_valid     : operands valid          in_ready  : can accept operands
//   a, b         : multiplicand/multiplier signed_mode: 1 = two's complement
//   out_valid    : product valid           out_ready : consumer takes product
//   product      : 2*WIDTH-bit result      busy      : in CALC or DONE
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   busy_q, busy_d;
  logic   load_c, step_c, last_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .step       (step_c),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .last_c     (last_c),
    .product    (product)
  );

  // Controller next-state; flag outputs are registered copies of the next state.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          load_c  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 1'b0, ir4, sm4 = 1'b0, ov4, or4 = 1'b1, busy4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;

  logic        iv8 = 1'b0, ir8, sm8 = 1'b0, ov8, or8 = 1'b1, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t        q4[$], q8[$];
  exp_t        e4, e8;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          handoffs4 = 0, handoffs8 = 0;
  int          last_accept = 0;
  bit          pend4 = 0, pend8 = 0;
  logic [15:0] hold4, hold8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend4 = 0;
    end else if (ov4) begin
      if (!pend4) begin
        if (q4.size() == 0) begin
          check("w4_unexpected_output", 16'(p4), 16'hxxxx);
        end else begin
          e4 = q4.pop_front();
          check("w4_product", 16'(p4), e4.prod);
          check("w4_latency", 16'(cyc), 16'(e4.due));
          hold4 = e4.prod;
        end
        pend4 = 1;
      end else begin
        check("w4_product_stable", 16'(p4), hold4);
      end
      if (or4) begin
        pend4 = 0;
        handoffs4++;
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend8 = 0;
    end else if (ov8) begin
      if (!pend8) begin
        if (q8.size() == 0) begin
          check("w8_unexpected_output", p8, 16'hxxxx);
        end else begin
          e8 = q8.pop_front();
          check("w8_product", p8, e8.prod);
          check("w8_latency", 16'(cyc), 16'(e8.due));
          hold8 = e8.prod;
        end
        pend8 = 1;
      end else begin
        check("w8_product_stable", p8, hold8);
        check("w8_in_ready_while_done", 16'(ir8), 16'd0);
      end
      if (or8) begin
        pend8 = 0;
        handoffs8++;
      end
    end
  end

  // Present operands until accepted; optionally push the expected result.
  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] prod, input bit push, input bit hold_valid);
    int n;
    int c;
    @(negedge clk);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; iv4 = 1'b1;
    end else begin
      a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    end
    n = 0;
    while (((w == 4) ? !ir4 : !ir8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timeout("accept_wait");
      iv4 = 1'b0;
      iv8 = 1'b0;
      return;
    end
    c = cyc;
    if (push) begin
      if (w == 4) q4.push_back('{prod, c + 1 + w});
      else        q8.push_back('{prod, c + 1 + w});
    end
    last_accept = c + 1;
    @(posedge clk);
    #1;
    if (!hold_valid) begin
      if (w == 4) iv4 = 1'b0;
      else        iv8 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0 || pend4 || pend8) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_prev;
    int n;
    int h;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready8", 16'(ir8), 16'd1);
    check("rst_out_valid8", 16'(ov8), 16'd0);
    check("rst_busy8", 16'(busy8), 16'd0);
    check("rst_product8", p8, 16'd0);
    check("rst_in_ready4", 16'(ir4), 16'd1);
    check("rst_product4", 16'(p4), 16'd0);
    rst_n = 1'b1;

    // WIDTH=4 unsigned
    issue(4, 8'h2, 8'h3, 1'b0, 16'h0006, 1, 0);
    issue(4, 8'hF, 8'hF, 1'b0, 16'h00E1, 1, 0);
    drain();

    // WIDTH=8 signed, including the most negative operand
    issue(8, 8'hFD, 8'h07, 1'b1, 16'hFFEB, 1, 0);
    issue(8, 8'h80, 8'h80, 1'b1, 16'h4000, 1, 0);
    issue(8, 8'h80, 8'h7F, 1'b1, 16'hC080, 1, 0);
    issue(8, 8'h07, 8'hFF, 1'b1, 16'hFFF9, 1, 0);
    issue(8, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 0);
    drain();

    // Backpressure: consumer stalls five cycles after out_valid
    or8 = 1'b0;
    issue(8, 8'd12, 8'd10, 1'b0, 16'd120, 1, 0);
    n = 0;
    while (!ov8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("bp_out_valid");
    repeat (5) begin
      @(negedge clk);
      check("bp_busy", 16'(busy8), 16'd1);
      check("bp_out_valid_held", 16'(ov8), 16'd1);
    end
    @(posedge clk);
    #1 or8 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handoff_out_valid", 16'(ov8), 16'd0);
    check("bp_handoff_in_ready", 16'(ir8), 16'd1);
    drain();

    // Back-to-back with in_valid and out_ready held high
    issue(8, 8'd5, 8'd5, 1'b0, 16'd25, 1, 1);
    acc_prev = last_accept;
    issue(8, 8'd0, 8'd9, 1'b0, 16'd0, 1, 1);
    check("b2b_gap1", 16'(last_accept - acc_prev), 16'd10);
    acc_prev = last_accept;
    issue(8, 8'd255, 8'd255, 1'b0, 16'd65025, 1, 0);
    check("b2b_gap2", 16'(last_accept - acc_prev), 16'd10);
    drain();

    // Asynchronous reset in the middle of a calculation
    issue(8, 8'd6, 8'd6, 1'b0, 16'd36, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 16'(ov8), 16'd0);
    check("rst_mid_in_ready", 16'(ir8), 16'd1);
    check("rst_mid_busy", 16'(busy8), 16'd0);
    check("rst_mid_product8", p8, 16'd0);
    check("rst_mid_product4", 16'(p4), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8, 8'd6, 8'd7, 1'b0, 16'd42, 1, 0);
    drain();

    // in_valid pulsed while busy must be ignored
    h = handoffs8;
    issue(8, 8'd5, 8'd3, 1'b0, 16'd15, 1, 0);
    @(posedge clk);
    #1;
    a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    check("busy_ignore_handoffs", 16'(handoffs8 - h), 16'd1);
    check("busy_ignore_queue_empty", 16'(q8.size()), 16'd0);
    check("busy_ignore_idle", 16'(ir8), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
